// File: rtl/display_arbiter.sv
// Shares the RG matrix, hex digits and beeper between the self-test (0) and two round-robin modes (1, 2).
// Optional build macro DISPLAY_ARBITER_OWNER_SHOW_EN shows the owner index in the top digit.
module display_arbiter #(
   parameter int MIN_HOLD  = 50000000,
   parameter int BLANK_CYC = 1000
) (
   input  logic         clk,
   input  logic         sw,
   input  logic [2:0]   req,
   input  logic [383:0] matrix_in,
   input  logic [95:0]  numbers_in,
   input  logic [2:0]   beep_in,
   output logic [2:0]   gnt,
   output logic         busy,
   output logic [127:0] matrixData,
   output logic [31:0]  numbersData,
   output logic         beep
);

   localparam int HOLD_W  = (MIN_HOLD  > 0) ? $clog2(MIN_HOLD + 1)  : 1;
   localparam int BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD);
   localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYC);
   localparam logic [31:0]        NUM_BLANK = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t               state_r;
   logic [1:0]           owner_r;
   logic [1:0]           last_rr_r;
   logic [HOLD_W-1:0]    hold_cnt_r;
   logic [BLANK_W-1:0]   blank_cnt_r;

   logic [127:0]         own_matrix_s;
   logic [31:0]          own_numbers_s;
   logic                 own_beep_s;
   logic                 owner_req_s;
   logic                 other_req_s;
   logic                 leave_s;
   logic                 pick_valid_s;
   logic [1:0]           pick_s;

   // Select the owner's data slice and decide whether the owner must give up the display.
   always_comb begin
      own_matrix_s  = 128'd0;
      own_numbers_s = NUM_BLANK;
      own_beep_s    = 1'b0;
      owner_req_s   = 1'b0;
      other_req_s   = 1'b0;
      case (owner_r)
         2'd0: begin
            own_matrix_s  = matrix_in[127:0];
            own_numbers_s = numbers_in[31:0];
            own_beep_s    = beep_in[0];
            owner_req_s   = req[0];
         end
         2'd1: begin
            own_matrix_s  = matrix_in[255:128];
            own_numbers_s = numbers_in[63:32];
            own_beep_s    = beep_in[1];
            owner_req_s   = req[1];
            other_req_s   = req[2];
         end
         2'd2: begin
            own_matrix_s  = matrix_in[383:256];
            own_numbers_s = numbers_in[95:64];
            own_beep_s    = beep_in[2];
            owner_req_s   = req[2];
            other_req_s   = req[1];
         end
         default: begin
            owner_req_s = 1'b0;
         end
      endcase
`ifdef DISPLAY_ARBITER_OWNER_SHOW_EN
      own_numbers_s[31:28] = {2'b00, owner_r};
`endif
      // Self-test is never preempted; modes yield to self-test at once and to each other after the hold.
      leave_s = ~owner_req_s
              | ((owner_r != 2'd0) & req[0])
              | ((owner_r != 2'd0) & other_req_s & (hold_cnt_r == HOLD_MAX));
   end

   // Arbitration: self-test first, otherwise the mode after the last granted mode.
   always_comb begin
      pick_valid_s = 1'b1;
      pick_s       = 2'd0;
      if (req[0]) begin
         pick_s = 2'd0;
      end else if (last_rr_r == 2'd1) begin
         if (req[2]) begin
            pick_s = 2'd2;
         end else if (req[1]) begin
            pick_s = 2'd1;
         end else begin
            pick_valid_s = 1'b0;
         end
      end else begin
         if (req[1]) begin
            pick_s = 2'd1;
         end else if (req[2]) begin
            pick_s = 2'd2;
         end else begin
            pick_valid_s = 1'b0;
         end
      end
   end

   // Ownership FSM with registered grant, busy and display outputs.
   always_ff @(posedge clk or negedge sw) begin
      if (!sw) begin
         state_r     <= IDLE;
         owner_r     <= 2'd0;
         last_rr_r   <= 2'd2;
         hold_cnt_r  <= '0;
         blank_cnt_r <= '0;
         gnt         <= 3'b000;
         busy        <= 1'b0;
         matrixData  <= 128'd0;
         numbersData <= NUM_BLANK;
         beep        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               matrixData  <= 128'd0;
               numbersData <= NUM_BLANK;
               beep        <= 1'b0;
               if (pick_valid_s) begin
                  state_r    <= OWN;
                  owner_r    <= pick_s;
                  gnt        <= 3'b001 << pick_s;
                  busy       <= 1'b1;
                  hold_cnt_r <= '0;
                  if (pick_s != 2'd0) begin
                     last_rr_r <= pick_s;
                  end
               end else begin
                  gnt  <= 3'b000;
                  busy <= 1'b0;
               end
            end
            OWN: begin
               if (leave_s) begin
                  state_r     <= BLANK;
                  gnt         <= 3'b000;
                  blank_cnt_r <= '0;
                  matrixData  <= 128'd0;
                  numbersData <= NUM_BLANK;
                  beep        <= 1'b0;
               end else begin
                  matrixData  <= own_matrix_s;
                  numbersData <= own_numbers_s;
                  beep        <= own_beep_s;
                  if (hold_cnt_r != HOLD_MAX) begin
                     hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                  end
               end
            end
            BLANK: begin
               gnt         <= 3'b000;
               matrixData  <= 128'd0;
               numbersData <= NUM_BLANK;
               beep        <= 1'b0;
               if (blank_cnt_r == BLANK_MAX) begin
                  state_r     <= IDLE;
                  busy        <= 1'b0;
                  blank_cnt_r <= '0;
               end else begin
                  blank_cnt_r <= blank_cnt_r + BLANK_W'(1);
               end
            end
            default: begin
               state_r     <= IDLE;
               gnt         <= 3'b000;
               busy        <= 1'b0;
               matrixData  <= 128'd0;
               numbersData <= NUM_BLANK;
               beep        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: directed scenarios followed by randomized request traffic.
module tb_display_arbiter;

   localparam int MIN_HOLD  = 8;
   localparam int BLANK_CYC = 2;

   logic         clk = 1'b0;
   logic         sw;
   logic [2:0]   req;
   logic [383:0] matrix_in;
   logic [95:0]  numbers_in;
   logic [2:0]   beep_in;
   logic [2:0]   gnt;
   logic         busy;
   logic [127:0] matrixData;
   logic [31:0]  numbersData;
   logic         beep;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]   gnt;
      logic         busy;
      logic [127:0] mat;
      logic [31:0]  num;
      logic         bp;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Reference model state: current owner (-1 = none), cycles held, edges left until idle, last mode served.
   int m_owner;
   int m_age;
   int m_gap;
   int m_last;

   logic [2:0] g_hist [0:29];

   always #5 clk = ~clk;

   display_arbiter #(.MIN_HOLD(MIN_HOLD), .BLANK_CYC(BLANK_CYC)) dut (
      .clk(clk), .sw(sw), .req(req), .matrix_in(matrix_in), .numbers_in(numbers_in),
      .beep_in(beep_in), .gnt(gnt), .busy(busy), .matrixData(matrixData),
      .numbersData(numbersData), .beep(beep)
   );

   task automatic model_edge();
      exp_t e;
      e.gnt  = 3'b000;
      e.busy = 1'b1;
      e.mat  = 128'd0;
      e.num  = 32'hFFFF_FFFF;
      e.bp   = 1'b0;
      if (m_owner >= 0) begin
         logic leave;
         leave = !req[m_owner] || (m_owner != 0 && req[0]) ||
                 (m_owner != 0 && req[3 - m_owner] && m_age >= MIN_HOLD);
         if (leave) begin
            m_owner = -1;
            m_gap   = BLANK_CYC + 1;
         end else begin
            if (m_age < MIN_HOLD) m_age++;
            e.mat = matrix_in[128*m_owner +: 128];
            e.num = numbers_in[32*m_owner +: 32];
            e.bp  = beep_in[m_owner];
`ifdef DISPLAY_ARBITER_OWNER_SHOW_EN
            e.num[31:28] = 4'(m_owner);
`endif
         end
      end else if (m_gap > 0) begin
         m_gap--;
         e.busy = (m_gap > 0);
      end else begin
         if (req[0]) m_owner = 0;
         else if (req[1] && (m_last == 2 || !req[2])) m_owner = 1;
         else if (req[2]) m_owner = 2;
         else m_owner = -1;
         if (m_owner > 0) m_last = m_owner;
         if (m_owner >= 0) m_age = 0;
         else e.busy = 1'b0;
      end
      if (m_owner >= 0) e.gnt = 3'(1 << m_owner);
      sb_q.push_back(e);
   endtask

   task automatic step(input logic [2:0] r, input bit rnd);
      @(negedge clk);
      req = r;
      if (rnd) begin
         for (int i = 0; i < 12; i++) matrix_in[32*i +: 32] = $urandom;
         numbers_in = {$urandom, $urandom, $urandom};
         beep_in    = 3'($urandom);
      end
      @(posedge clk);
      model_edge();
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares every registered output once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_tests++;
         if (gnt !== mon_e.gnt || busy !== mon_e.busy || matrixData !== mon_e.mat ||
             numbersData !== mon_e.num || beep !== mon_e.bp) begin
            n_fail++;
            $display("FAIL cycle t=%0t gnt %b/%b busy %b/%b num %h/%h beep %b/%b mat %h/%h (got/expected)",
                     $time, gnt, mon_e.gnt, busy, mon_e.busy, numbersData, mon_e.num,
                     beep, mon_e.bp, matrixData, mon_e.mat);
         end
         n_tests++;
         if (!$onehot0(gnt)) begin
            n_fail++;
            $display("FAIL onehot t=%0t gnt %b", $time, gnt);
         end
      end
   end

   initial begin
      logic [2:0] r;
      sw = 1'b0;
      req = 3'b000;
      matrix_in = '0;
      numbers_in = '0;
      beep_in = 3'b000;
      m_owner = -1; m_age = 0; m_gap = 0; m_last = 2;
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt", 128'(gnt), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_matrix", matrixData, 128'd0);
      check("reset_numbers", 128'(numbersData), 128'hFFFF_FFFF);
      check("reset_beep", 128'(beep), 128'd0);
      @(negedge clk);
      sw = 1'b1;

      // Reset in the middle of a grant.
      matrix_in = {128'd0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 128'd0};
      repeat (4) step(3'b010, 1'b0);
      #1 check("pre_reset_matrix", matrixData, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
      @(negedge clk);
      #2 sw = 1'b0;
      req = 3'b000;
      #1;
      check("async_rst_gnt", 128'(gnt), 128'd0);
      check("async_rst_matrix", matrixData, 128'd0);
      check("async_rst_numbers", 128'(numbersData), 128'hFFFF_FFFF);
      check("async_rst_beep", 128'(beep), 128'd0);
      sb_q.delete();
      m_owner = -1; m_age = 0; m_gap = 0; m_last = 2;
      @(negedge clk);
      sw = 1'b1;
      step(3'b110, 1'b1);
      #1 check("first_grant_after_reset", 128'(gnt), 128'b010);

      // Single request with a known digit pattern.
      repeat (6) step(3'b000, 1'b1);
      numbers_in[63:32] = 32'h1234_5678;
      step(3'b010, 1'b0);
      #1 check("single_gnt", 128'(gnt), 128'b010);
      check("single_first_cycle_blank", 128'(numbersData), 128'hFFFF_FFFF);
      step(3'b010, 1'b0);
      #1 check("single_numbers", 128'(numbersData), 128'h1234_5678);
      step(3'b010, 1'b0);
      step(3'b000, 1'b0);
      #1 check("release_gnt", 128'(gnt), 128'd0);
      check("release_numbers", 128'(numbersData), 128'hFFFF_FFFF);
      repeat (2) step(3'b000, 1'b0);
      #1 check("busy_still_high", 128'(busy), 128'd1);
      step(3'b000, 1'b0);
      #1 check("busy_falls", 128'(busy), 128'd0);

      // Self-test preemption, then self-test is never preempted.
      repeat (4) step(3'b100, 1'b1);
      step(3'b101, 1'b1);
      #1 check("preempt_gnt_drop", 128'(gnt), 128'd0);
      repeat (3) step(3'b101, 1'b1);
      step(3'b101, 1'b1);
      #1 check("selftest_gnt", 128'(gnt), 128'b001);
      repeat (100) step(3'b011, 1'b1);
      #1 check("selftest_kept", 128'(gnt), 128'b001);

      // Round-robin rotation with both modes requesting.
      repeat (5) step(3'b000, 1'b1);
      for (int i = 0; i < 30; i++) begin
         step(3'b110, 1'b1);
         #1 g_hist[i] = gnt;
      end
      check("rr_first", 128'(g_hist[0]), 128'b010);
      check("rr_hold_end", 128'(g_hist[8]), 128'b010);
      check("rr_blank", 128'(g_hist[9]), 128'd0);
      check("rr_gap_end", 128'(g_hist[12]), 128'd0);
      check("rr_second", 128'(g_hist[13]), 128'b100);
      check("rr_second_end", 128'(g_hist[21]), 128'b100);
      check("rr_blank2", 128'(g_hist[22]), 128'd0);
      check("rr_back", 128'(g_hist[26]), 128'b010);

      // Owner 1 releases at hold 3 while mode 2 waits.
      step(3'b100, 1'b1);
      #1 check("early_release", 128'(gnt), 128'd0);
      repeat (3) step(3'b100, 1'b1);
      #1 check("early_gap", 128'(gnt), 128'd0);
      step(3'b100, 1'b1);
      #1 check("early_next", 128'(gnt), 128'b100);

      // Owner indication in the top digit.
      numbers_in = {32'h8888_8888, 32'h0123_4567, 32'h89AB_CDEF};
      repeat (3) step(3'b100, 1'b0);
`ifdef DISPLAY_ARBITER_OWNER_SHOW_EN
      #1 check("owner_show", 128'(numbersData), 128'h2888_8888);
`else
      #1 check("owner_show", 128'(numbersData), 128'h8888_8888);
`endif

      // Randomized request traffic with slowly changing levels.
      r = 3'b000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) r[0] = ~r[0];
         if ($urandom_range(0, 11) == 0) r[1] = ~r[1];
         if ($urandom_range(0, 11) == 0) r[2] = ~r[2];
         step(r, 1'b1);
      end
      repeat (6) step(3'b000, 1'b1);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the board's display and sound resources between three requesters: the 128-bit RG dot matrix, the 8-digit hex number display, and the beeper.
- Requester 0 is the power-on self-test and has absolute priority. Requesters 1 and 2 are application modes and alternate round-robin, each with a minimum hold time.
- A blanking gap is inserted on every ownership change so that no frame mixes two sources.
- Sits between the mode modules and the matrix, number and beeper drivers.

Parameters:
- MIN_HOLD, default 50000000: minimum clk cycles an owner 1/2 keeps the grant before another 1/2 requester may preempt it.
- BLANK_CYC, default 1000: clk cycles of blank output between owners. 0 is legal.

Ports:
- clk  in  1  system clock
- sw  in  1  main switch; reset is asynchronous and active-low
- req  in  3  request per requester; level, held while display wanted
- matrix_in  in  384  requester i matrix data at bits [128*i+127:128*i]
- numbers_in  in  96  requester i digit data at bits [32*i+31:32*i]
- beep_in  in  3  requester i beeper level
- gnt  out  3  one-hot grant; all zero when nobody owns the display
- busy  out  1  high whenever state is not IDLE
- matrixData  out  128  registered matrix output
- numbersData  out  32  registered digit output; nibble F means digit hidden
- beep  out  1  registered beeper output

Behaviour:
- Blank value: matrixData = 0, numbersData = 32'hFFFF_FFFF, beep = 0.
- Reset (sw low, asynchronous, takes effect immediately, also mid-grant):
  - state = IDLE, gnt = 0, busy = 0, outputs = blank.
  - hold_cnt = 0, blank_cnt = 0, last_rr = 2, so requester 1 wins first.
- FSM states are IDLE, OWN and BLANK.
- IDLE:
  - Outputs blank.
  - If req[0] is high, grant 0. Otherwise grant the first requesting of 1/2 after last_rr. If none is requesting, stay in IDLE.
  - On grant: gnt goes one-hot at that edge, state goes to OWN, hold_cnt = 0. last_rr updates only when 1 or 2 is granted.
- OWN:
  - Each edge registers the owner's matrix/numbers/beep slice into the outputs. Latency is 1 cycle: in the first cycle gnt is high the outputs are still blank, and owner data appears from the next edge.
  - hold_cnt increments each cycle and saturates at MIN_HOLD.
  - Exit to BLANK (gnt cleared at that edge; outputs blank from the same edge) on any of:
    - (a) owner's req low (release);
    - (b) owner is 1 or 2 and req[0] high (immediate preemption, hold ignored);
    - (c) owner is 1 or 2, the other of 1/2 is requesting, and hold_cnt == MIN_HOLD (rotation).
  - Owner 0 is never preempted.
  - If (a) and (b) occur together, the result is identical: go to BLANK.
- BLANK:
  - gnt = 0, outputs blank, blank_cnt counts up.
  - After BLANK_CYC cycles in BLANK, state goes to IDLE and blank_cnt = 0.
  - With BLANK_CYC = 0, BLANK lasts exactly one cycle.
  - req changes during BLANK are ignored; arbitration happens only in IDLE.
- Total switch gap from the release edge to the new gnt is BLANK_CYC+2 cycles.
- gnt is always one-hot or zero. A grant never goes to a requester whose req is low at the arbitration edge.
- Counter widths are sized to hold MIN_HOLD and BLANK_CYC without wrap.

Optional Feature:
- Macro: DISPLAY_ARBITER_OWNER_SHOW_EN.
- Defined: while in OWN, numbersData[31:28] is forced to {2'b00, owner index}, i.e. 0, 1 or 2. This shows which mode holds the display. Bits [27:0] follow the owner normally. During IDLE/BLANK the nibble stays F.
- Undefined: numbersData is entirely the owner's data; no extra logic is present.

Test Plan (MIN_HOLD=8, BLANK_CYC=2):
1. Reset mid-grant: owner 1 granted with matrix_in slice = 128'hAA.., pull sw low between edges -> gnt=0, matrixData=0, numbersData=FFFF_FFFF, beep=0 immediately, before the next edge; after release the first grant goes to 1.
2. Single request: req=3'b010, numbers_in[63:32]=32'h1234_5678 -> gnt=010 one edge later, numbersData=1234_5678 the edge after that; drop req -> gnt=0 and outputs blank at that edge, busy falls 3 cycles later.
3. Self-test preemption: owner 2 granted after 3 cycles, raise req[0] -> next edge gnt=000, BLANK 2 cycles, IDLE, then gnt=001; requester 0 holding 100 cycles while req[1] is high is never preempted.
4. Round-robin rotation: req=3'b110 held -> 1 granted; after 8 cycles of hold plus 1 transition edge, BLANK (gnt=0); then gnt=100; after 8 more cycles, back to 010; no gnt overlap, always one-hot.
5. Release before hold expires: owner 1 drops req at hold_cnt=3 while req[2] is high -> BLANK immediately, 2 granted BLANK_CYC+2 cycles after the release edge.
6. With DISPLAY_ARBITER_OWNER_SHOW_EN, owner 2, numbers_in slice=32'h8888_8888 -> numbersData=2888_8888; without the macro -> 8888_8888.
